// File: rtl/apc_stream_accumulator_if.sv
// apc_stream_accumulator_if: count stream in, result stream out.
// Both directions use a valid/ready handshake.
interface apc_stream_accumulator_if #(
  parameter int ACC_WIDTH = 12
);
  logic                 in_valid;
  logic [3:0]           in_sum;
  logic                 in_ready;
  logic                 out_valid;
  logic [ACC_WIDTH:0]   out_data;
  logic                 out_ready;

  modport master (
    output in_valid,
    output in_sum,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_sum,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/apc_stream_accumulator.sv
// apc_stream_accumulator: sums STREAM_LEN APC counts per stream
// and returns a unipolar count or a bipolar signed value.
module apc_stream_accumulator #(
  parameter int STREAM_LEN = 256,
  parameter int ACC_WIDTH  = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic mode,
  output logic busy,
  apc_stream_accumulator_if.slave bus
);
  localparam int CW = $clog2(STREAM_LEN);
  localparam logic [CW-1:0] LAST = CW'(STREAM_LEN - 1);
  localparam logic [ACC_WIDTH:0] BIAS =
    (ACC_WIDTH + 1)'(15 * STREAM_LEN);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  state_t state;
  state_t state_d;

  logic [ACC_WIDTH-1:0] acc;
  logic [CW-1:0]        cnt;
  logic                 mode_q;
  logic [ACC_WIDTH:0]   data_q;

  logic                 fire;
  logic                 last;
  logic                 load;
  logic [ACC_WIDTH-1:0] sum_w;
  logic [ACC_WIDTH:0]   result;

  assign fire  = (state == ACCUM) && bus.in_valid;
  assign last  = fire && (cnt == LAST);
  assign load  = start && ((state == IDLE) ||
                 ((state == DONE) && bus.out_ready));
  assign sum_w = acc + ACC_WIDTH'(bus.in_sum);

  // 2*final - 15*N is the bipolar value; width ACC_WIDTH+1 always fits.
  assign result = mode_q ? ({sum_w, 1'b0} - BIAS)
                         : {1'b0, sum_w};

  assign bus.in_ready  = (state == ACCUM);
  assign bus.out_valid = (state == DONE);
  assign bus.out_data  = data_q;
  assign busy          = (state != IDLE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state: DONE may chain straight into a new stream.
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (start) state_d = ACCUM;
      end
      ACCUM: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = start ? ACCUM : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: clear on a new stream, add on each beat, latch result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      cnt    <= '0;
      mode_q <= 1'b0;
      data_q <= '0;
    end else begin
      if (load) begin
        acc    <= '0;
        cnt    <= '0;
        mode_q <= mode;
      end else if (fire) begin
        acc <= sum_w;
        cnt <= cnt + CW'(1);
      end
      if (last) data_q <= result;
    end
  end
endmodule

// File: tb/tb_apc_stream_accumulator.sv
// tb_apc_stream_accumulator: random and directed streams on
// N=256 and N=4 instances, checked against an arithmetic model.
module tb_apc_stream_accumulator;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic l_rst, l_start, l_mode, l_busy;
  logic s_rst, s_start, s_mode, s_busy;

  apc_stream_accumulator_if #(.ACC_WIDTH(12)) l_if ();
  apc_stream_accumulator_if #(.ACC_WIDTH(12)) s_if ();

  apc_stream_accumulator #(
    .STREAM_LEN(256),
    .ACC_WIDTH (12)
  ) u_long (
    .clk  (clk),
    .rst  (l_rst),
    .start(l_start),
    .mode (l_mode),
    .busy (l_busy),
    .bus  (l_if.slave)
  );

  apc_stream_accumulator #(
    .STREAM_LEN(4),
    .ACC_WIDTH (12)
  ) u_short (
    .clk  (clk),
    .rst  (s_rst),
    .start(s_start),
    .mode (s_mode),
    .busy (s_busy),
    .bus  (s_if.slave)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] model(input bit m,
                                        input int sum,
                                        input int n);
    int v;
    v = m ? (2 * sum - 15 * n) : sum;
    return 13'(v);
  endfunction

  // pat: 0 all 15, 1 all 0, 2 alternating 7/8, 3 random
  task automatic run_long(input bit m, input int pat,
                          input bit stall);
    int sum, n, cyc, v, h;
    logic [12:0] e;
    sum = 0; n = 0;
    @(negedge clk);
    l_start = 1'b1; l_mode = m; l_if.in_valid = 1'b1;
    l_if.in_sum = 4'd15;
    @(negedge clk);
    l_start = 1'b0; l_mode = 1'($urandom);
    cyc = 1;
    chk("l_rdy_up", 32'(l_if.in_ready), 1);
    while (n < 256) begin
      if (stall && $urandom_range(0, 3) == 0) begin
        l_if.in_valid = 1'b0;
        l_if.in_sum = 4'($urandom);
      end else begin
        case (pat)
          0: v = 15;
          1: v = 0;
          2: v = (n % 2) ? 8 : 7;
          default: v = $urandom_range(0, 15);
        endcase
        l_if.in_valid = 1'b1;
        l_if.in_sum = 4'(v);
        sum += v;
        n++;
      end
      @(negedge clk);
      cyc++;
    end
    l_if.in_valid = 1'b0;
    e = model(m, sum, 256);
    if (!stall) chk("l_latency", 32'(cyc), 257);
    chk("l_ovalid", 32'(l_if.out_valid), 1);
    chk("l_irdy_dn", 32'(l_if.in_ready), 0);
    chk("l_data", 32'(l_if.out_data), 32'(e));
    h = $urandom_range(0, 3);
    repeat (h) begin
      @(negedge clk);
      chk("l_hold_v", 32'(l_if.out_valid), 1);
      chk("l_hold_d", 32'(l_if.out_data), 32'(e));
    end
    l_if.out_ready = 1'b1;
    @(negedge clk);
    l_if.out_ready = 1'b0;
    chk("l_idle_v", 32'(l_if.out_valid), 0);
    chk("l_idle_b", 32'(l_busy), 0);
    chk("l_keep_d", 32'(l_if.out_data), 32'(e));
  endtask

  // gap stall cycles, then one beat; noise pokes start/mode
  task automatic s_feed(input int v, input int gap,
                        input bit noise, inout int sum);
    repeat (gap) begin
      s_if.in_valid = 1'b0;
      s_if.in_sum = 4'($urandom);
      if (noise) begin
        s_start = 1'b1;
        s_mode = ~s_mode;
      end
      @(negedge clk);
    end
    s_if.in_valid = 1'b1;
    s_if.in_sum = 4'(v);
    s_start = noise;
    @(negedge clk);
    s_if.in_valid = 1'b0;
    s_start = 1'b0;
    sum += v;
  endtask

  task automatic s_begin(input bit m);
    @(negedge clk);
    s_start = 1'b1; s_mode = m;
    @(negedge clk);
    s_start = 1'b0; s_mode = ~m;
    chk("s_rdy_up", 32'(s_if.in_ready), 1);
  endtask

  task automatic s_result(input string tag, input bit m,
                          input int sum);
    chk({tag, "_v"}, 32'(s_if.out_valid), 1);
    chk({tag, "_r"}, 32'(s_if.in_ready), 0);
    chk({tag, "_d"}, 32'(s_if.out_data), 32'(model(m, sum, 4)));
  endtask

  task automatic s_release();
    s_if.out_ready = 1'b1;
    @(negedge clk);
    s_if.out_ready = 1'b0;
    chk("s_idle", 32'(s_busy), 0);
  endtask

  initial begin
    int sum, m2, nxt;
    bit m, b2b;
    logic [12:0] e;
    l_rst = 1'b1; s_rst = 1'b1;
    l_start = 1'b0; l_mode = 1'b0;
    s_start = 1'b0; s_mode = 1'b0;
    l_if.in_valid = 1'b0; l_if.in_sum = '0; l_if.out_ready = 1'b0;
    s_if.in_valid = 1'b0; s_if.in_sum = '0; s_if.out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_l_v", 32'(l_if.out_valid), 0);
    chk("rst_l_r", 32'(l_if.in_ready), 0);
    chk("rst_l_d", 32'(l_if.out_data), 0);
    chk("rst_l_b", 32'(l_busy), 0);
    chk("rst_s_v", 32'(s_if.out_valid), 0);
    chk("rst_s_r", 32'(s_if.in_ready), 0);
    l_rst = 1'b0; s_rst = 1'b0;
    @(negedge clk);
    chk("idle_l_r", 32'(l_if.in_ready), 0);

    run_long(1'b0, 0, 1'b0);
    run_long(1'b1, 0, 1'b0);
    run_long(1'b1, 1, 1'b0);
    run_long(1'b1, 2, 1'b0);
    run_long(1'b0, 3, 1'b1);
    run_long(1'b1, 3, 1'b1);

    // counts 1,2,3,4 with gaps 0/3/1; start pokes ignored
    sum = 0;
    s_begin(1'b0);
    s_feed(1, 0, 1'b0, sum);
    s_feed(2, 0, 1'b1, sum);
    s_feed(3, 3, 1'b1, sum);
    s_feed(4, 1, 1'b1, sum);
    chk("s10_sum", 32'(sum), 10);
    s_result("s10", 1'b0, 10);
    repeat (5) begin
      s_start = 1'b1;
      @(negedge clk);
      chk("s_bp_v", 32'(s_if.out_valid), 1);
      chk("s_bp_d", 32'(s_if.out_data), 10);
    end
    s_if.out_ready = 1'b1; s_start = 1'b1; s_mode = 1'b1;
    @(negedge clk);
    s_if.out_ready = 1'b0; s_start = 1'b0; s_mode = 1'b0;
    chk("s_b2b_r", 32'(s_if.in_ready), 1);
    chk("s_b2b_v", 32'(s_if.out_valid), 0);
    chk("s_b2b_b", 32'(s_busy), 1);
    sum = 0;
    s_feed(15, 0, 1'b0, sum);
    s_feed(0, 0, 1'b0, sum);
    s_feed(9, 2, 1'b0, sum);
    s_feed(4, 0, 1'b0, sum);
    s_result("s_b2b", 1'b1, sum);
    chk("s_b2b_neg", 32'(s_if.out_data), 32'(13'h1ffc));
    s_release();

    // async abort after two beats
    sum = 0;
    s_begin(1'b0);
    s_feed(5, 0, 1'b0, sum);
    s_feed(6, 0, 1'b0, sum);
    #2 s_rst = 1'b1;
    #1;
    chk("s_ab_v", 32'(s_if.out_valid), 0);
    chk("s_ab_r", 32'(s_if.in_ready), 0);
    chk("s_ab_b", 32'(s_busy), 0);
    chk("s_ab_d", 32'(s_if.out_data), 0);
    @(negedge clk);
    s_rst = 1'b0;
    @(negedge clk);
    chk("s_ab_nov", 32'(s_if.out_valid), 0);
    sum = 0;
    s_begin(1'b0);
    repeat (4) s_feed(15, 0, 1'b0, sum);
    s_result("s60", 1'b0, 60);
    s_release();

    // random streams with stalls, back-pressure, chaining
    b2b = 1'b0;
    m = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (!b2b) begin
        m = 1'($urandom);
        s_begin(m);
      end
      sum = 0;
      for (int j = 0; j < 4; j++)
        s_feed($urandom_range(0, 15), $urandom_range(0, 2),
               1'($urandom), sum);
      s_result("s_rnd", m, sum);
      e = model(m, sum, 4);
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        chk("s_rnd_hold", 32'(s_if.out_data), 32'(e));
      end
      b2b = 1'($urandom);
      m2 = $urandom_range(0, 1);
      s_if.out_ready = 1'b1;
      s_start = b2b;
      s_mode = 1'(m2);
      @(negedge clk);
      s_if.out_ready = 1'b0;
      s_start = 1'b0;
      nxt = b2b ? 1 : 0;
      chk("s_rnd_next", 32'(s_if.in_ready), 32'(nxt));
      chk("s_rnd_ov", 32'(s_if.out_valid), 0);
      m = 1'(m2);
      s_mode = ~m;
    end
    if (b2b) begin
      sum = 0;
      repeat (4) s_feed(1, 0, 1'b0, sum);
      s_result("s_tail", m, sum);
      s_release();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
